// File: rtl/pixel_stream_packer.sv
// Shades raster-ordered ray-march pixels to RGB, buffers them in a first-word-fall-through FIFO
// and emits AXI4-Stream video (tuser = start of frame, tlast = end of line). DEPTH_SHADE_EN selects depth shading.
module pixel_stream_packer #(
  parameter int          H_RES       = 640,
  parameter int          V_RES       = 480,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [23:0] BG_COLOR    = 24'h000000,
  parameter logic [23:0] FG_COLOR    = 24'hFFFFFF,
  parameter int          DEPTH_SHIFT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [95:0]                   surface_point_in,
  input  logic                          hit_in,
  input  logic                          pixel_valid_in,
  output logic [23:0]                   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int XW = (H_RES > 2) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 2) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  logic [23:0]   color_p0;
  logic [23:0]   color_p1;
  logic          vld_p1;

  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [LW-1:0] level;
  logic          empty;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          drop;

  // The x/y components are never used for colour; only depth matters.
  logic unused_coords;
  assign unused_coords = ^surface_point_in[95:32];

`ifdef DEPTH_SHADE_EN
  logic signed [31:0] z_p0;
  logic               unused_fg;

  // Map positive depth to a falling grey level, saturating at black and at white for z <= 0.
  function automatic logic [7:0] depth_shade(input logic signed [31:0] z);
    logic signed [31:0] d;
    d = z >>> (21 - DEPTH_SHIFT);
    if (z <= 32'sd0)
      return 8'hFF;
    else if (d >= 32'sd255)
      return 8'h00;
    else
      return 8'hFF - d[7:0];
  endfunction

  function automatic logic [23:0] hit_color(input logic signed [31:0] z);
    logic [7:0] s;
    s = depth_shade(z);
    return {s, s, s};
  endfunction

  assign z_p0      = surface_point_in[31:0];
  assign unused_fg = ^FG_COLOR;
  assign color_p0  = hit_in ? hit_color(z_p0) : BG_COLOR;
`else
  logic unused_depth;
  assign unused_depth = ^{surface_point_in[31:0], (DEPTH_SHIFT > 0)};
  assign color_p0     = hit_in ? FG_COLOR : BG_COLOR;
`endif

  // ---- p0 -> p1: shade register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= pixel_valid_in;
  end

  always_ff @(posedge clk) begin
    if (pixel_valid_in) color_p1 <= color_p0;
  end

  // ---- p1 -> FIFO ----
  assign level = wptr - rptr;
  assign empty = (level == '0);
  assign full  = (level == LW'(FIFO_DEPTH));
  assign pop   = m_axis_tvalid & m_axis_tready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = vld_p1 & (~full | pop);
  assign drop  = vld_p1 & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= color_p1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + (AW+1)'(1);
      if (pop)   rptr <= rptr + (AW+1)'(1);
      if (drop)  overflow <= 1'b1;
    end
  end

  // ---- FIFO -> AXI-Stream: frame sequencing and raster position ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (en) state <= RUN;
        end
        RUN: begin
          if (pop) begin
            if (x == X_LAST) begin
              x <= '0;
              if (y == Y_LAST) begin
                y          <= '0;
                frame_done <= 1'b1;
                if (!en) state <= IDLE;
              end else begin
                y <= y + YW'(1);
              end
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Everything below is derived from registers only, so it holds steady while stalled.
  assign m_axis_tvalid = (state == RUN) && !empty;
  assign m_axis_tdata  = m_axis_tvalid ? mem[rptr[AW-1:0]] : '0;
  assign m_axis_tuser  = m_axis_tvalid && (x == '0) && (y == '0);
  assign m_axis_tlast  = m_axis_tvalid && (x == X_LAST);
  assign fifo_level    = level;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Bench for pixel_stream_packer: directed and randomised pixels checked against a queue model
// of shading, FIFO order, raster sideband and frame_done.
module tb_pixel_stream_packer;

  localparam int          H     = 4;
  localparam int          V     = 2;
  localparam int          DEPTH = 16;
  localparam int          SHIFT = 4;
  localparam logic [23:0] BG    = 24'h000000;
  localparam logic [23:0] FG    = 24'hFFFFFF;
`ifdef DEPTH_SHADE_EN
  localparam bit SHADE_ON = 1'b1;
`else
  localparam bit SHADE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [95:0] surface_point_in;
  logic        hit_in;
  logic        pixel_valid_in;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        frame_done;
  logic        overflow;
  logic [4:0]  fifo_level;

  pixel_stream_packer #(
    .H_RES(H), .V_RES(V), .FIFO_DEPTH(DEPTH),
    .BG_COLOR(BG), .FG_COLOR(FG), .DEPTH_SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .surface_point_in(surface_point_in), .hit_in(hit_in), .pixel_valid_in(pixel_valid_in),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .frame_done(frame_done), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [23:0] exp_q[$];
  int          out_idx = 0;
  int          fd_count = 0;
  int          pop_count = 0;
  logic        fd_expect = 1'b0;
  logic        hold_pending = 1'b0;
  logic [25:0] hold_val = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference colour: grey level falls by one per 2^-SHIFT units of depth.
  function automatic logic [23:0] model_color(input logic h, input int z);
    int          d;
    logic [7:0]  s;
    logic [23:0] shaded;
    d = z / (1 << (21 - SHIFT));
    if (z <= 0)        s = 8'd255;
    else if (d >= 255) s = 8'd0;
    else               s = 8'(255 - d);
    shaded = {s, s, s};
    if (!h) return BG;
    return SHADE_ON ? shaded : FG;
  endfunction

  function automatic int rand_z();
    return int'($urandom_range(32'h0240_0000, 0)) - 32'sh0040_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic h, input int z, input bit keep);
    pixel_valid_in   = 1'b1;
    hit_in           = h;
    surface_point_in = {32'($urandom()), 32'($urandom()), z};
    if (keep) exp_q.push_back(model_color(h, z));
  endtask

  task automatic send(input logic h, input int z, input bit keep);
    drive(h, z, keep);
    tick();
    pixel_valid_in = 1'b0;
  endtask

  task automatic send_rand(input bit keep);
    send(1'($urandom_range(1, 0)), rand_z(), keep);
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    pixel_valid_in = 1'b0;
    m_axis_tready  = 1'b0;
    exp_q.delete();
    out_idx = 0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    m_axis_tready = 1'b1;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < budget) begin
      tick();
      n++;
    end
    check("drain_remaining", exp_q.size(), 0);
    tick();
    tick();
  endtask

  // Scoreboard: every handshake is compared with the model, stalls must hold the beat.
  always @(negedge clk) begin
    if (!rst) begin
      fd_expect    = 1'b0;
      hold_pending = 1'b0;
    end else begin
      check("frame_done", frame_done, fd_expect);
      if (frame_done) fd_count++;
      if (hold_pending) begin
        check("hold_tvalid", m_axis_tvalid, 1);
        check("hold_beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, hold_val);
      end
      fd_expect = 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        pop_count++;
        if (exp_q.size() == 0) begin
          check("pop_without_pixel", m_axis_tvalid, 0);
        end else begin
          check("tdata", m_axis_tdata, exp_q.pop_front());
          check("tuser", m_axis_tuser, (out_idx % (H * V)) == 0);
          check("tlast", m_axis_tlast, (out_idx % H) == H - 1);
          fd_expect = ((out_idx % (H * V)) == H * V - 1);
          out_idx++;
        end
      end
      hold_pending = m_axis_tvalid && !m_axis_tready;
      hold_val     = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    int f0;
    rst = 1'b1; en = 1'b0; m_axis_tready = 1'b0;
    pixel_valid_in = 1'b0; hit_in = 1'b0; surface_point_in = '0;
    #1 rst = 1'b0;
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tuser", m_axis_tuser, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_level", fifo_level, 0);
    tick();
    tick();
    rst = 1'b1;

    // 1: first-pixel latency and shade of z = 1.0
    en = 1'b1; m_axis_tready = 1'b1;
    tick();
    send(1'b1, 32'h0020_0000, 1'b1);
    tick();
    check("t1_tvalid", m_axis_tvalid, 1);
    check("t1_tdata", m_axis_tdata, SHADE_ON ? 24'hEFEFEF : FG);
    check("t1_tuser", m_axis_tuser, 1);
    check("t1_tlast", m_axis_tlast, 0);
    drain(50);

    // 2: one full frame back-to-back, then the counters wrap to (0,0)
    do_reset();
    en = 1'b1; m_axis_tready = 1'b1;
    tick();
    p0 = pop_count; f0 = fd_count;
    for (int i = 0; i < H * V; i++) send_rand(1'b1);
    drain(50);
    check("t2_outputs", pop_count - p0, H * V);
    check("t2_frame_done_count", fd_count - f0, 1);
    m_axis_tready = 1'b0;
    send_rand(1'b1);
    tick();
    check("t2_wrap_tuser", m_axis_tuser, 1);
    check("t2_wrap_tlast", m_axis_tlast, 0);
    drain(50);

    // Random gaps on both sides of the FIFO
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) != 0) drive(1'($urandom_range(1, 0)), rand_z(), 1'b1);
      else pixel_valid_in = 1'b0;
      m_axis_tready = ($urandom_range(3, 0) != 0);
      tick();
    end
    pixel_valid_in = 1'b0;
    drain(200);

    // 3: overflow on the 17th push with the sink stalled
    do_reset();
    en = 1'b1;
    tick();
    p0 = pop_count;
    for (int i = 0; i < DEPTH; i++) send_rand(1'b1);
    send_rand(1'b0);
    check("t3_level_full", fifo_level, DEPTH);
    check("t3_ovf_before", overflow, 0);
    tick();
    check("t3_ovf_after", overflow, 1);
    check("t3_level_held", fifo_level, DEPTH);
    drain(100);
    check("t3_outputs", pop_count - p0, DEPTH);
    check("t3_ovf_sticky", overflow, 1);

    // 4: push and pop together at full
    do_reset();
    en = 1'b1;
    tick();
    p0 = pop_count;
    for (int i = 0; i < DEPTH; i++) send_rand(1'b1);
    tick();
    check("t4_level_full", fifo_level, DEPTH);
    drive(1'b1, rand_z(), 1'b1);
    tick();
    pixel_valid_in = 1'b0;
    m_axis_tready  = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    check("t4_level_same", fifo_level, DEPTH);
    check("t4_no_ovf", overflow, 0);
    drain(100);
    check("t4_outputs", pop_count - p0, DEPTH + 1);

    // 5: en dropped mid-frame takes effect only at the frame boundary
    do_reset();
    en = 1'b1; m_axis_tready = 1'b1;
    tick();
    p0 = pop_count;
    for (int i = 0; i < 3; i++) send_rand(1'b1);
    en = 1'b0;
    for (int i = 0; i < H * V - 3; i++) send_rand(1'b1);
    for (int i = 0; i < 3; i++) send_rand(1'b1);
    repeat (6) tick();
    check("t5_idle_tvalid", m_axis_tvalid, 0);
    check("t5_idle_level", fifo_level, 3);
    check("t5_frame_out", pop_count - p0, H * V);
    en = 1'b1;
    tick();
    check("t5_resume_tvalid", m_axis_tvalid, 1);
    check("t5_resume_tuser", m_axis_tuser, 1);
    drain(50);

    // 6: miss, negative depth, far depth; then reset mid-stream
    do_reset();
    en = 1'b1;
    tick();
    send(1'b0, rand_z(), 1'b1);
    send(1'b1, 32'hFFE0_0000, 1'b1);
    send(1'b1, 32'h0800_0000, 1'b1);
    tick();
    check("t6_miss", m_axis_tdata, 24'h000000);
    m_axis_tready = 1'b1;
    tick();
    check("t6_neg_depth", m_axis_tdata, 24'hFFFFFF);
    tick();
    check("t6_far_depth", m_axis_tdata, SHADE_ON ? 24'h000000 : FG);
    tick();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) send_rand(1'b1);
    tick();
    rst = 1'b0;
    #1;
    check("t6_rst_tvalid", m_axis_tvalid, 0);
    check("t6_rst_level", fifo_level, 0);
    check("t6_rst_tdata", m_axis_tdata, 0);
    exp_q.delete();
    out_idx = 0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    send_rand(1'b1);
    tick();
    check("t6_restart_tuser", m_axis_tuser, 1);
    drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
